button_debounce: RTL and testbench
==================================

// Module: button_debounce
// PURPOSE
//   Conditions a raw asynchronous push-button input into a clean, debounced level.
//   Also produces single-cycle press, release and long-press event pulses.
//   Sits directly upstream of the delayed reset generator: Level drives its BTNS input.
//   Event pulses are available to user logic, for example mode stepping.
// PARAMETERS
//   SYNC_STAGES      2        synchroniser flops on Button; must be >= 2
//   DEBOUNCE_CYCLES  1000000  consecutive stable synced cycles required to accept a change; must be >= 2
//   HOLD_CYCLES      50000000 cycles Level must stay high (counted from Press) before LongPress; must be >= 1
//   Counter widths are derived with $clog2(param+1).
// PORTS
//   Clk        in   1  system clock; all logic on posedge
//   nReset     in   1  asynchronous active-low reset
//   Button     in   1  raw, bouncy, asynchronous button input
//   Level      out  1  debounced button level, registered
//   Press      out  1  1-cycle pulse; asserted in the same cycle Level rises
//   Release    out  1  1-cycle pulse; asserted in the same cycle Level falls
//   LongPress  out  1  1-cycle pulse; at most once per press
// BEHAVIOUR
//   Reset:
//   - nReset low: sync chain, state, DbCount and HoldCount go to 0 immediately (no clock needed).
//   - Also immediately: state=IDLE, Level=0, Press=0, Release=0, LongPress=0.
//   Synchroniser:
//   - S is the last flop of an SYNC_STAGES-long chain on Button.
//   - Only S is seen by the FSM; Button is never used directly.
//   FSM states, evaluated each posedge from the registered S:
//   - IDLE:      S=1 -> ARMING, DbCount<=0.
//   - ARMING:    S=0 -> IDLE, DbCount<=0 (bounce rejected).
//                Else if DbCount==DEBOUNCE_CYCLES-1 -> PRESSED, Level<=1, Press<=1, HoldCount<=0.
//                Else DbCount++.
//   - PRESSED:   S=0 -> RELEASING, DbCount<=0.
//                HoldCount++ every cycle in PRESSED or RELEASING, saturating at HOLD_CYCLES.
//   - RELEASING: S=1 -> PRESSED, DbCount<=0; HoldCount is kept, no Press.
//                Else if DbCount==DEBOUNCE_CYCLES-1 -> IDLE, Level<=0, Release<=1, HoldCount<=0.
//                Else DbCount++.
//   LongPress:
//   - Asserted for exactly the cycle in which HoldCount transitions HOLD_CYCLES-1 -> HOLD_CYCLES.
//   - Saturation guarantees a single pulse per press.
//   Pulses:
//   - Press, Release and LongPress default to 0 every cycle.
//   - They are never asserted together; Press and Release can never coincide.
//   Latency:
//   - Button stable from before edge 1: S=1 at edge SYNC_STAGES; ARMING at edge SYNC_STAGES+1.
//   - Level/Press rise at edge SYNC_STAGES+DEBOUNCE_CYCLES+1. Release uses the same latency.
//   Boundary cases:
//   - Any single S dropout during ARMING restarts the count from IDLE.
//   - A dropout shorter than DEBOUNCE_CYCLES during PRESSED does not affect Level.
//   - Button held high through reset release is treated as a fresh press and produces Press.
//   - Async reset mid-press clears Level with no Release pulse.
//   - Counters never wrap: DbCount is bounded by the FSM; HoldCount saturates.
// TESTING  (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10)
//   Reset with Button=1:
//   - All outputs read 0 while nReset=0.
//   - nReset released before edge 1 -> Level=1 and Press=1 after edge 7; Press=0 after edge 8.
//   Clean press then release (Button 0->1 held 20 cycles, then 0):
//   - Press pulse is 1 cycle wide, 7 edges after the rise.
//   - Release pulse is 1 cycle wide, 7 edges after the fall.
//   Bounce on press (Button 1,1,1,0,1,1,1,1,... one value per cycle):
//   - Level stays 0 through the dropout.
//   - Level rises 7 edges after the final 0->1; exactly one Press.
//   Glitch while pressed (Button low for 2 cycles during PRESSED):
//   - Level remains 1; no Release; no extra Press.
//   - LongPress timing is unchanged.
//   Long hold (Button high 30 cycles):
//   - LongPress asserted exactly once, 10 edges after Press.
//   - No further LongPress; a new press after release yields a new LongPress.
//   Async reset mid-PRESSED (nReset low between edges):
//   - Level=0 with no clock edge; no Release pulse.
//   - After reset release with Button still 1, a new Press at +7 edges.

Source files
------------

// File: rtl/button_debounce.sv
// Push-button conditioner: synchroniser, debounce FSM and single-cycle
// press / release / long-press event pulses.
module button_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000
) (
  input  logic Clk,
  input  logic nReset,
  input  logic Button,
  output logic Level,
  output logic Press,
  output logic Release,
  output logic LongPress
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW  = $clog2(HOLD_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARMING, PRESSED, RELEASING} state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [DBW-1:0]         db_cnt_q, db_cnt_d;
  logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   long_q, long_d;
  logic                   hold_inc;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], Button};
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    level_d    = level_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    hold_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d  = ARMING;
          db_cnt_d = '0;
        end
      end
      ARMING: begin
        if (!s) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = PRESSED;
          level_d    = 1'b1;
          press_d    = 1'b1;
          hold_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DBW'(1);
        end
      end
      PRESSED: begin
        hold_inc = 1'b1;
        if (!s) begin
          state_d  = RELEASING;
          db_cnt_d = '0;
        end
      end
      RELEASING: begin
        if (s) begin
          state_d  = PRESSED;
          db_cnt_d = '0;
          hold_inc = 1'b1;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = IDLE;
          level_d    = 1'b0;
          release_d  = 1'b1;
          hold_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DBW'(1);
          hold_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Saturation at HOLD_CYCLES is what limits LongPress to one pulse per press
    if (hold_inc && hold_cnt_q != HOLD_MAX) begin
      hold_cnt_d = hold_cnt_q + HW'(1);
      long_d     = (hold_cnt_q == HOLD_LAST);
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      sync_q     <= '0;
      state_q    <= IDLE;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
    end
  end

  assign Level     = level_q;
  assign Press     = press_q;
  assign Release   = release_q;
  assign LongPress = long_q;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed scenarios plus random bouncing, checked
// against a run-length model of the debounce rules.
module tb_button_debounce;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int HOLD = 10;

  logic Clk = 1'b0;
  logic nReset = 1'b0;
  logic Button = 1'b0;
  logic Level, Press, Release, LongPress;

  int checks = 0;
  int errors = 0;

  // Model: button delay line, run of samples disagreeing with level, press time
  logic hist [SYNC];
  logic m_level, m_press, m_rel, m_long;
  int   run, cyc, press_edge;

  button_debounce #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD)) dut (
    .Clk(Clk), .nReset(nReset), .Button(Button),
    .Level(Level), .Press(Press), .Release(Release), .LongPress(LongPress)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
    m_level = 1'b0; m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
    run = 0; press_edge = -1000;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".level"},   Level,     m_level);
    check({tag, ".press"},   Press,     m_press);
    check({tag, ".release"}, Release,   m_rel);
    check({tag, ".long"},    LongPress, m_long);
  endtask

  // One clock with Button=b; model advances on the edge, outputs checked #1 later
  task automatic step(input logic b, input string tag);
    logic s, prev;
    Button = b;
    @(posedge Clk);
    cyc++;
    s = hist[SYNC-1];
    for (int i = SYNC-1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = b;
    prev = m_level;
    m_press = 1'b0; m_rel = 1'b0;
    run = (s != m_level) ? run + 1 : 0;
    if (run == DB + 1) begin
      m_level = ~m_level;
      run = 0;
      if (m_level) begin m_press = 1'b1; press_edge = cyc; end
      else m_rel = 1'b1;
    end
    m_long = prev && m_level && (cyc - press_edge == HOLD);
    #1;
    check_all(tag);
  endtask

  task automatic steps(input logic b, input int n, input string tag);
    for (int i = 0; i < n; i++) step(b, tag);
  endtask

  initial begin
    int len, npress, nlong;
    logic v;
    cyc = 0;
    model_reset();

    // Reset with Button held high
    Button = 1'b1;
    #12;
    check_all("in_reset");
    @(negedge Clk);
    nReset = 1'b1;
    steps(1'b1, 6, "rst_btn_hi");
    step(1'b1, "rst_btn_hi");
    check("edge7.level", Level, 1'b1);
    check("edge7.press", Press, 1'b1);
    step(1'b1, "rst_btn_hi");
    check("edge8.press", Press, 1'b0);

    // Long hold then release; count LongPress pulses
    nlong = 0;
    for (int i = 0; i < 22; i++) begin step(1'b1, "long_hold"); if (LongPress) nlong++; end
    check("long_once", nlong == 1, 1'b1);
    steps(1'b0, 12, "release");

    // Bounce on press: exactly one Press afterwards
    steps(1'b1, 3, "bounce");
    step(1'b0, "bounce");
    check("bounce.level_low", Level, 1'b0);
    npress = 0;
    for (int i = 0; i < 12; i++) begin step(1'b1, "bounce"); if (Press) npress++; end
    check("bounce.one_press", npress == 1, 1'b1);
    steps(1'b0, 12, "bounce_rel");

    // Glitch while pressed: level holds, long-press timing unchanged
    nlong = 0;
    steps(1'b1, 10, "glitch");
    steps(1'b0, 2, "glitch");
    for (int i = 0; i < 20; i++) begin step(1'b1, "glitch"); if (LongPress) nlong++; end
    check("glitch.level_hi", Level, 1'b1);
    check("glitch.long_once", nlong == 1, 1'b1);

    // Async reset mid-press: Level clears without a clock edge, no Release
    #3 nReset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    repeat (3) @(posedge Clk);
    #2 nReset = 1'b1;
    steps(1'b1, 7, "after_rst");
    check("after_rst.press", Press, 1'b1);
    steps(1'b1, 12, "after_rst");
    steps(1'b0, 12, "after_rst_rel");

    // Random bouncing: mostly short runs, some long enough to be accepted
    v = 1'b0;
    for (int seg = 0; seg < 80; seg++) begin
      v = ~v;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 20) : $urandom_range(1, 6);
      steps(v, len, "random");
    end
    steps(1'b0, 12, "final");
    check("final.level_low", Level, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
